perf_counter_ctrl: RTL
======================

PERF_COUNTER_CTRL -- requirements
Module: perf_counter_ctrl

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state changes on posedge clk.
REQ-002 SHALL have rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have pipeline_continue, input, 1, high = pipeline advances this cycle, low = stalled.
REQ-004 SHALL have ev, input, 4, per-cycle event pulses; ev[i] feeds counter i.
REQ-005 SHALL have mem_address, input, 32, MEM-stage data address.
REQ-006 SHALL have mem_wdata, input, 32, MEM-stage store data.
REQ-007 SHALL have mem_read and mem_write, input, 1 each, MEM-stage access strobes.
REQ-008 SHALL have mem_rdata, input, 32, load data returned by the data cache.
REQ-009 SHALL have read_out and write_out, output, 1 each, strobes forwarded to the data cache.
REQ-010 SHALL have data_out, output, 32, load data returned to the pipeline.
REQ-011 SHALL have busy, output, 1, high while a snapshot or clear-all sequence runs.

Function
REQ-012 SHALL decode word addresses 0x50-0x56 as local; for these, read_out=0 and write_out=0; all other addresses pass mem_read/mem_write through unchanged, combinationally.
REQ-013 SHALL map: 0x50-0x53 SHADOW[i] (RO; a write clears COUNT[i]); 0x54 CTRL (RW; [3:0] enable, [4] freeze); 0x55 STATUS (RO [8]=busy; [3:0] sticky overflow, write-1-to-clear); 0x56 CMD (WO; [0] snapshot, [1] clear-all; reads return 0).
REQ-014 SHALL apply MMIO write side effects only in cycles with pipeline_continue=1, so a stalled store acts once.
REQ-015 SHALL increment COUNT[i] (32-bit) when ev[i]=1, CTRL[i]=1, CTRL[4]=0, and no clear of COUNT[i] occurs that cycle; ev is counted regardless of pipeline_continue.
REQ-016 SHALL wrap COUNT[i] from 0xFFFFFFFF to 0 and set STATUS[i] in the same edge.
REQ-017 SHALL give priority, when the same bit is set by overflow and cleared by a W1C write in one cycle, to the set.
REQ-018 SHALL give priority, when a clear of COUNT[i] (MMIO or CLR state) and an increment coincide, to the clear; the result is 0.
REQ-019 SHALL implement FSM states IDLE, SNAP, CLR with a 2-bit index idx.
REQ-020 SHALL, in IDLE, on an accepted CMD write with [0]=1, go to SNAP with idx=0; with [0]=0 and [1]=1, go to CLR with idx=0; with both bits set, run SNAP then CLR.
REQ-021 SHALL, in SNAP, copy COUNT[idx] pre-increment value into SHADOW[idx] each cycle and advance idx; after idx=3, go to CLR if clear-all is pending, else IDLE.
REQ-022 SHALL, in CLR, zero COUNT[idx] each cycle and advance idx; after idx=3, go to IDLE and clear the pending flag.
REQ-023 SHALL ignore CMD writes while busy=1; busy = (state != IDLE), combinational from state.
REQ-024 SHALL never stall for FSM progress; SNAP and CLR advance every cycle regardless of pipeline_continue.
REQ-025 SHALL form local read data combinationally from mem_address, capture it and a swap flag (mem_read and local address) into holding registers loaded only when pipeline_continue=1.
REQ-026 SHALL drive data_out = held local data when the held swap flag is 1, else mem_rdata.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set COUNT=0, SHADOW=0, CTRL=0x0000000F, STATUS[3:0]=0, state=IDLE, idx=0, pending=0, held swap=0, held data=0.
REQ-028 SHALL abort any SNAP/CLR sequence on reset; partially updated shadows are zeroed.
REQ-029 SHALL give rst priority over every other update in the same cycle.

Verification
REQ-030 Reset, then ev=4'b0001 for 10 cycles, CMD write 0x1, wait until busy=0, load 0x50 -> data_out=10 one cycle later; read_out=0.
REQ-031 Force COUNT[2]=0xFFFFFFFE, ev[2]=1 for 2 cycles -> COUNT[2]=0, STATUS=0x4; write 0x4 to 0x55 -> STATUS=0x0.
REQ-032 CMD write 0x3 with COUNT={5,6,7,8} and events off -> busy high 8 cycles; SHADOW={5,6,7,8}; COUNT all 0.
REQ-033 Store to 0x51 held with pipeline_continue=0 for 3 cycles while ev[1]=1 -> COUNT[1] counts, then clears exactly once on the continue cycle, result 0.
REQ-034 CTRL=0x10 (freeze), ev=4'hF for 5 cycles -> all COUNT unchanged; load 0x100 -> read_out=1, data_out=mem_rdata.
REQ-035 Assert rst during CLR at idx=2 -> next cycle busy=0, CTRL=0xF, all COUNT=0.

Source files
------------

// File: rtl/perf_counter_ctrl.sv
// Four 32-bit event counters with MMIO control, snapshot shadows and a
// sequenced snapshot / clear-all engine that never stalls the pipeline.
module perf_counter_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_continue,
    input  logic [3:0]  ev,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        read_out,
    output logic        write_out,
    output logic [31:0] data_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        CLR  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        pend_q, pend_d;

    logic [31:0] count_q  [4];
    logic [31:0] count_d  [4];
    logic [31:0] shadow_q [4];
    logic [31:0] shadow_d [4];
    logic [31:0] ctrl_q, ctrl_d;
    logic [3:0]  status_q, status_d;

    logic        swap_q;
    logic [31:0] hold_q;

    logic        local_hit;
    logic [2:0]  sel;
    logic        wr_acc;
    logic        snap_en;
    logic        clr_fsm;
    logic [3:0]  ovf;
    logic [3:0]  w1c;
    logic [31:0] rd_data;

    assign local_hit = (mem_address >= 32'h50) && (mem_address <= 32'h56);
    assign sel       = mem_address[2:0];
    assign wr_acc    = mem_write && local_hit && pipeline_continue;
    assign read_out  = mem_read  && !local_hit;
    assign write_out = mem_write && !local_hit;
    assign busy      = (state_q != IDLE);
    assign data_out  = swap_q ? hold_q : mem_rdata;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        snap_en = 1'b0;
        clr_fsm = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_acc && sel == 3'd6) begin
                    if (mem_wdata[0]) begin
                        state_d = SNAP;
                        idx_d   = 2'd0;
                        pend_d  = mem_wdata[1];
                    end else if (mem_wdata[1]) begin
                        state_d = CLR;
                        idx_d   = 2'd0;
                    end
                end
            end
            SNAP: begin
                snap_en = 1'b1;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = pend_q ? CLR : IDLE;
                end
            end
            CLR: begin
                clr_fsm = 1'b1;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // A clear always beats an increment; an overflow set beats a W1C clear.
    always_comb begin
        ovf = '0;
        for (int i = 0; i < 4; i++) begin
            count_d[i]  = count_q[i];
            shadow_d[i] = shadow_q[i];
            if ((wr_acc && sel == 3'(i)) || (clr_fsm && idx_q == 2'(i))) begin
                count_d[i] = '0;
            end else if (ev[i] && ctrl_q[i] && !ctrl_q[4]) begin
                {ovf[i], count_d[i]} = {1'b0, count_q[i]} + 33'd1;
            end
            if (snap_en && idx_q == 2'(i)) begin
                shadow_d[i] = count_q[i];
            end
        end
        w1c      = (wr_acc && sel == 3'd5) ? mem_wdata[3:0] : 4'd0;
        status_d = (status_q & ~w1c) | ovf;
        ctrl_d   = (wr_acc && sel == 3'd4) ? mem_wdata : ctrl_q;
    end

    always_comb begin
        rd_data = '0;
        if (local_hit) begin
            case (sel)
                3'd0, 3'd1, 3'd2, 3'd3: rd_data = shadow_q[sel[1:0]];
                3'd4:                   rd_data = ctrl_q;
                3'd5:                   rd_data = {23'd0, busy, 4'd0, status_q};
                default:                rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            ctrl_q   <= 32'h0000_000F;
            status_q <= '0;
            swap_q   <= 1'b0;
            hold_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                count_q[i]  <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            for (int i = 0; i < 4; i++) begin
                count_q[i]  <= count_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            if (pipeline_continue) begin
                swap_q <= mem_read && local_hit;
                hold_q <= rd_data;
            end
        end
    end

endmodule
